// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared arbiter state encoding, TIMEOUT limits and index-width helper.
package axi_arb_pkg;
  typedef enum logic {IDLE, GRANTED} arb_state_e;
  localparam int TIMEOUT_MIN = 2;
  localparam int TIMEOUT_MAX = 65535;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_arb_mask_enc.sv
// axi_arb_mask_enc: picks the highest-priority set bit of req (one-hot and binary index).
module axi_arb_mask_enc import axi_arb_pkg::*; #(
  parameter int PORTS = 4,
  parameter int LSB_HIGH = 1,
  localparam int IW = idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req,
  output logic             valid,
  output logic [IW-1:0]    index,
  output logic [PORTS-1:0] onehot
);
  logic [PORTS-1:0] r, iso;
  // Reverse when the MSB is highest so the lowest-set-bit trick serves both orders.
  assign r      = (LSB_HIGH != 0) ? req : {<<{req}};
  assign iso    = r & (~r + PORTS'(1));
  assign onehot = (LSB_HIGH != 0) ? iso : {<<{iso}};
  assign valid  = |req;
  always_comb begin
    index = '0;
    for (int k = 0; k < PORTS; k++)
      if (onehot[k]) index = IW'(k);
  end
endmodule

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin / fixed-priority arbiter with registered one-hot grant.
// Optional grant timeout enabled by defining AXI_RR_ARBITER_TIMEOUT_EN.
module axi_rr_arbiter import axi_arb_pkg::*; #(
  parameter int PORTS = 4,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int ARB_BLOCK = 1,
  parameter int ARB_BLOCK_ACK = 1,
  parameter int ARB_LSB_HIGH = 1,
  parameter int TIMEOUT = 256,
  localparam int IW = idx_w(PORTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_encoded,
  output logic             timeout_pulse
);
  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d, mask_q, mask_d, m_oh, u_oh, win_oh, next_mask;
  logic [IW-1:0]    enc_q, enc_d, m_idx, u_idx, win_idx;
  logic             m_v, u_v, use_m, release_hit, timeout_hit, arbitrate, pulse_q, pulse_d;

  axi_arb_mask_enc #(.PORTS(PORTS), .LSB_HIGH(ARB_LSB_HIGH)) u_masked (
    .req(request & mask_q), .valid(m_v), .index(m_idx), .onehot(m_oh)
  );
  axi_arb_mask_enc #(.PORTS(PORTS), .LSB_HIGH(ARB_LSB_HIGH)) u_unmasked (
    .req(request), .valid(u_v), .index(u_idx), .onehot(u_oh)
  );

  assign use_m   = (ARB_ROUND_ROBIN != 0) && m_v;
  assign win_oh  = use_m ? m_oh : u_oh;
  assign win_idx = use_m ? m_idx : u_idx;
  // Keep only ports of strictly lower priority than the winner for the next round.
  assign next_mask = (ARB_LSB_HIGH != 0) ? ~(win_oh | (win_oh - PORTS'(1))) : win_oh - PORTS'(1);
  assign release_hit = (ARB_BLOCK == 0) ? 1'b1 :
                       (ARB_BLOCK_ACK != 0) ? |(acknowledge & grant_q) : ~|(request & grant_q);
  assign arbitrate = (state_q == IDLE) || release_hit || timeout_hit;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    enc_d   = enc_q;
    mask_d  = mask_q;
    pulse_d = 1'b0;
    if (arbitrate) begin
      state_d = u_v ? GRANTED : IDLE;
      grant_d = u_v ? win_oh : '0;
      enc_d   = u_v ? win_idx : '0;
      mask_d  = u_v ? next_mask : mask_q;
      pulse_d = timeout_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      enc_q   <= '0;
      mask_q  <= '1;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef AXI_RR_ARBITER_TIMEOUT_EN
  localparam int TO = (TIMEOUT < TIMEOUT_MIN) ? TIMEOUT_MIN :
                      (TIMEOUT > TIMEOUT_MAX) ? TIMEOUT_MAX : TIMEOUT;
  logic [15:0] cnt_q, cnt_d;
  assign timeout_hit = (state_q == GRANTED) && (cnt_q == 16'(TO - 1));
  // Counts consecutive cycles the same grant is held; any change restarts it.
  assign cnt_d = ((state_q == GRANTED) && !timeout_hit && (ARB_BLOCK == 0 || !release_hit) &&
                  (grant_d == grant_q)) ? cnt_q + 16'd1 : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign grant         = grant_q;
  assign grant_valid   = |grant_q;
  assign grant_encoded = enc_q;
  assign timeout_pulse = pulse_q;
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed checks of round-robin, fixed-priority, request-drop, timeout and reset.
module tb_axi_rr_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  logic [3:0] rr_req = '0, rr_ack = '0, rr_gnt;
  logic [3:0] fp_req = '0, fp_ack = '0, fp_gnt;
  logic [3:0] rd_req = '0, rd_ack = '0, rd_gnt;
  logic [3:0] to_req = '0, to_ack = '0, to_gnt;
  logic [1:0] rr_enc, fp_enc, rd_enc, to_enc;
  logic rr_v, fp_v, rd_v, to_v, rr_to, fp_to, rd_to, to_to;
  logic p1_req = 1'b0, p1_ack = 1'b0, p1_gnt, p1_v, p1_enc, p1_to;

  axi_rr_arbiter u_rr (.clk(clk), .rst_n(rst_n), .request(rr_req), .acknowledge(rr_ack),
    .grant(rr_gnt), .grant_valid(rr_v), .grant_encoded(rr_enc), .timeout_pulse(rr_to));
  axi_rr_arbiter #(.ARB_ROUND_ROBIN(0), .ARB_LSB_HIGH(0)) u_fp (.clk(clk), .rst_n(rst_n),
    .request(fp_req), .acknowledge(fp_ack), .grant(fp_gnt), .grant_valid(fp_v),
    .grant_encoded(fp_enc), .timeout_pulse(fp_to));
  axi_rr_arbiter #(.ARB_BLOCK_ACK(0)) u_rd (.clk(clk), .rst_n(rst_n), .request(rd_req),
    .acknowledge(rd_ack), .grant(rd_gnt), .grant_valid(rd_v), .grant_encoded(rd_enc),
    .timeout_pulse(rd_to));
  axi_rr_arbiter #(.TIMEOUT(8)) u_to (.clk(clk), .rst_n(rst_n), .request(to_req),
    .acknowledge(to_ack), .grant(to_gnt), .grant_valid(to_v), .grant_encoded(to_enc),
    .timeout_pulse(to_to));
  axi_rr_arbiter #(.PORTS(1)) u_p1 (.clk(clk), .rst_n(rst_n), .request(p1_req),
    .acknowledge(p1_ack), .grant(p1_gnt), .grant_valid(p1_v), .grant_encoded(p1_enc),
    .timeout_pulse(p1_to));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_gnt", 32'(rr_gnt), 0);
    chk("rst_v", 32'(rr_v), 0);
    chk("rst_enc", 32'(rr_enc), 0);
    chk("rst_to", 32'(rr_to), 0);
    rr_req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_gnt", 32'(rr_gnt), 'h1);
    chk("first_enc", 32'(rr_enc), 0);
    chk("first_v", 32'(rr_v), 1);
    step();
    chk("hold_no_ack", 32'(rr_gnt), 'h1);
    // Acknowledge each grant in turn: 1 -> 2 -> 4 -> 8 -> wrap to 1, no idle cycle.
    for (int i = 0; i < 4; i++) begin
      rr_ack = 4'(1 << i);
      step();
      chk("rr_seq", 32'(rr_gnt), 32'(1 << ((i + 1) % 4)));
      chk("rr_seq_v", 32'(rr_v), 1);
      chk("rr_seq_enc", 32'(rr_enc), 32'((i + 1) % 4));
    end
    step();
    chk("ack_other_port", 32'(rr_gnt), 'h1);
    rr_req = 4'b0000; rr_ack = 4'b0001;
    step();
    chk("idle_gnt", 32'(rr_gnt), 0);
    chk("idle_v", 32'(rr_v), 0);
    rr_ack = 4'b0000; rr_req = 4'b0100;
    step();
    chk("req2_gnt", 32'(rr_gnt), 'h4);
    chk("req2_enc", 32'(rr_enc), 2);
    rr_req = 4'b0000;
    step();
    chk("hold_after_drop", 32'(rr_gnt), 'h4);
    rr_ack = 4'b0100;
    step();
    chk("release_idle", 32'(rr_gnt), 0);
    rr_ack = 4'b0000; rr_req = 4'b0010;
    step();
    chk("wrap_fallback", 32'(rr_gnt), 'h2);
    rr_ack = 4'b0010; rr_req = 4'b0001;
    step();
    chk("ack_new_req_same_edge", 32'(rr_gnt), 'h1);
    chk("ack_new_req_enc", 32'(rr_enc), 0);
    rr_ack = 4'b0001; rr_req = 4'b0000;
    step();
    rr_ack = 4'b0000;

    fp_req = 4'b0101;
    step();
    chk("fp_gnt", 32'(fp_gnt), 'h4);
    chk("fp_enc", 32'(fp_enc), 2);
    fp_ack = 4'b0001;
    step();
    chk("fp_hold", 32'(fp_gnt), 'h4);
    fp_ack = 4'b0100; fp_req = 4'b0001;
    step();
    chk("fp_move", 32'(fp_gnt), 'h1);
    chk("fp_move_enc", 32'(fp_enc), 0);
    fp_ack = 4'b0000;

    rd_req = 4'b0010;
    step();
    chk("rd_gnt", 32'(rd_gnt), 'h2);
    rd_req = 4'b1010; rd_ack = 4'b0001;
    step();
    chk("rd_hold", 32'(rd_gnt), 'h2);
    rd_req = 4'b1000;
    step();
    chk("rd_drop_gnt", 32'(rd_gnt), 'h8);
    chk("rd_drop_enc", 32'(rd_enc), 3);
    rd_ack = 4'b0000;

    to_req = 4'b0100;
    step();
    chk("to_first", 32'(to_gnt), 'h4);
    to_req = 4'b0101;
    repeat (7) step();
    chk("to_before_gnt", 32'(to_gnt), 'h4);
    chk("to_before_pulse", 32'(to_to), 0);
    step();
`ifdef AXI_RR_ARBITER_TIMEOUT_EN
    chk("to_pulse", 32'(to_to), 1);
    chk("to_regrant", 32'(to_gnt), 'h1);
    step();
    chk("to_pulse_once", 32'(to_to), 0);
    chk("to_after", 32'(to_gnt), 'h1);
`else
    chk("to_disabled_pulse", 32'(to_to), 0);
    chk("to_disabled_hold", 32'(to_gnt), 'h4);
`endif

    p1_req = 1'b1;
    step();
    chk("p1_gnt", 32'(p1_gnt), 1);
    chk("p1_enc", 32'(p1_enc), 0);
    p1_ack = 1'b1;
    step();
    chk("p1_regrant", 32'(p1_gnt), 1);
    p1_req = 1'b0;
    step();
    chk("p1_idle", 32'(p1_gnt), 0);
    p1_ack = 1'b0;

    rr_req = 4'b0010;
    step();
    chk("mid_gnt", 32'(rr_gnt), 'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(rr_gnt), 0);
    chk("async_v", 32'(rr_v), 0);
    chk("async_enc", 32'(rr_enc), 0);
    chk("async_to", 32'(rr_to), 0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_gnt", 32'(rr_gnt), 'h2);
    chk("post_rst_enc", 32'(rr_enc), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
